// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Rev     : 1.0
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int REG_AW          = 4;
    localparam int MUL_LAT_DEFAULT = 4;
    localparam int MCNT_W          = 4;

    typedef enum logic {IDLE, MUL_BUSY} pctrl_state_t;

    // Busy-cycle count loaded on issue; the issue and done cycles are not part of it.
    function automatic logic [MCNT_W-1:0] mul_cnt_load(input int lat);
        return (lat > 1) ? MCNT_W'(lat - 2) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating up-counter with synchronous clear (clear beats increment).
// Rev     : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl
// Brief   : Five-stage pipeline hazard/sequencing controller: load-use stalls,
//           branch flushes, multi-cycle multiply hold, stall/flush counters.
// Rev     : 1.0
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] WA3E,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              BranchTakenE,
    input  logic              MulStartE,
    input  logic              CntClr,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              StallE,
    output logic              FlushM,
    output logic              MulDoneE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    localparam bit              c_MUL_MULTI = (MUL_LAT > 1);
    localparam logic [MCNT_W-1:0] c_MCNT_LOAD = mul_cnt_load(MUL_LAT);

    pctrl_state_t      r_state;
    logic [MCNT_W-1:0] r_mcnt;

    logic              w_lwstall;
    logic              w_mul_issue;
    logic              w_stall_inc;
    logic              w_flush_inc;
    logic [CNT_W-1:0]  w_stall_cnt;
    logic [CNT_W-1:0]  w_flush_cnt;

    assign w_lwstall   = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
    assign w_mul_issue = c_MUL_MULTI & MulStartE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_mcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mul_issue) begin
                        r_state <= MUL_BUSY;
                        r_mcnt  <= c_MCNT_LOAD;
                    end
                end
                MUL_BUSY: begin
                    if (r_mcnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_mcnt <= r_mcnt - MCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_mcnt  <= '0;
                end
            endcase
        end
    end

    // Hazard outputs are combinational; everything is forced low while in reset.
    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        StallE   = 1'b0;
        FlushM   = 1'b0;
        MulDoneE = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (w_mul_issue) begin
                        // The multiply wins over any simultaneous branch or hazard.
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end else begin
                        StallF   = w_lwstall;
                        StallD   = w_lwstall;
                        FlushD   = BranchTakenE;
                        FlushE   = w_lwstall | BranchTakenE;
                        MulDoneE = ~c_MUL_MULTI & MulStartE;
                    end
                end
                MUL_BUSY: begin
                    if (r_mcnt == '0) begin
                        MulDoneE = 1'b1;
                    end else begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end
                end
                default: begin
                    StallF = 1'b0;
                end
            endcase
        end
    end

    assign w_stall_inc = StallF;
    assign w_flush_inc = FlushD | FlushE;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .clr   (CntClr),
        .count (w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .clr   (CntClr),
        .count (w_flush_cnt)
    );

    assign StallCnt = reset ? w_stall_cnt : '0;
    assign FlushCnt = reset ? w_flush_cnt : '0;

    a_no_mul_with_branch: assert property (
        @(posedge clk) disable iff (!reset)
        (r_state == IDLE) |-> !(MulStartE && BranchTakenE)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_ctrl
// Brief   : Directed + randomized bench for pipeline_ctrl against a cycle model.
// Rev     : 1.0
// ============================================================================
module tb_pipeline_ctrl;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       RA1D, RA2D, WA3E;
    logic             RegWriteE, MemtoRegE, BranchTakenE, MulStartE, CntClr;
    logic             StallF, StallD, FlushD, FlushE, StallE, FlushM, MulDoneE;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .WA3E         (WA3E),
        .RegWriteE    (RegWriteE),
        .MemtoRegE    (MemtoRegE),
        .BranchTakenE (BranchTakenE),
        .MulStartE    (MulStartE),
        .CntClr       (CntClr),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .StallE       (StallE),
        .FlushM       (FlushM),
        .MulDoneE     (MulDoneE),
        .StallCnt     (StallCnt),
        .FlushCnt     (FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: Execute cycles of the in-flight multiply still to come, plus counts.
    int m_left = 0;
    int m_scnt = 0;
    int m_fcnt = 0;

    always @(negedge clk) begin : model
        bit lw, e_sf, e_fd, e_fe, e_se, e_md;
        lw   = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
        e_sf = 0; e_fd = 0; e_fe = 0; e_se = 0; e_md = 0;
        if (reset) begin
            if (m_left > 1 || (m_left == 0 && MulStartE && MUL_LAT > 1)) begin
                e_sf = 1; e_se = 1;
            end else if (m_left == 1) begin
                e_md = 1;
            end else begin
                e_sf = lw;
                e_fd = BranchTakenE;
                e_fe = lw || BranchTakenE;
                e_md = MulStartE && (MUL_LAT == 1);
            end
        end
        chk("StallF", StallF, e_sf);
        chk("StallD", StallD, e_sf);
        chk("FlushD", FlushD, e_fd);
        chk("FlushE", FlushE, e_fe);
        chk("StallE", StallE, e_se);
        chk("FlushM", FlushM, e_se);
        chk("MulDoneE", MulDoneE, e_md);
        chk("StallCnt", int'(StallCnt), reset ? m_scnt : 0);
        chk("FlushCnt", int'(FlushCnt), reset ? m_fcnt : 0);

        if (!reset) begin
            m_left = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (CntClr) begin
                m_scnt = 0; m_fcnt = 0;
            end else begin
                if (e_sf && m_scnt < CMAX) m_scnt++;
                if ((e_fd || e_fe) && m_fcnt < CMAX) m_fcnt++;
            end
            if (m_left > 0)                          m_left--;
            else if (MulStartE && MUL_LAT > 1)       m_left = MUL_LAT - 1;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        RA1D = 0; RA2D = 0; WA3E = 0;
        RegWriteE = 0; MemtoRegE = 0; BranchTakenE = 0; MulStartE = 0; CntClr = 0;
    endtask

    initial begin
        reset = 1'b0;
        quiet();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA1D = 5; BranchTakenE = 1;
        nxt(); nxt(); #2;
        chk("rst_StallF", StallF, 0);
        chk("rst_FlushE", FlushE, 0);

        // Load-use
        nxt(); reset = 1'b1; quiet();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA1D = 5; RA2D = 2; #2;
        chk("lu_StallF", StallF, 1);
        chk("lu_FlushE", FlushE, 1);
        chk("lu_FlushD", FlushD, 0);
        nxt(); quiet(); #2;
        chk("lu_StallCnt", int'(StallCnt), 1);
        chk("lu_FlushCnt", int'(FlushCnt), 1);

        // Branch
        nxt(); BranchTakenE = 1; #2;
        chk("br_FlushD", FlushD, 1);
        chk("br_StallF", StallF, 0);
        nxt(); quiet(); #2;
        chk("br_FlushCnt", int'(FlushCnt), 2);

        // Multiply with a branch during the busy phase
        nxt(); MulStartE = 1; #2;
        chk("mul_StallE_t0", StallE, 1);
        chk("mul_Done_t0", MulDoneE, 0);
        nxt(); MulStartE = 0; BranchTakenE = 1; #2;
        chk("mul_FlushE_t1", FlushE, 0);
        chk("mul_FlushM_t1", FlushM, 1);
        nxt(); quiet(); #2;
        chk("mul_StallE_t2", StallE, 1);
        nxt(); #2;
        chk("mul_Done_t3", MulDoneE, 1);
        chk("mul_StallF_t3", StallF, 0);
        nxt(); #2;
        chk("mul_StallCnt", int'(StallCnt), 4);
        chk("mul_FlushCnt", int'(FlushCnt), 2);

        // Reset in the middle of a multiply
        nxt(); MulStartE = 1;
        nxt(); MulStartE = 0; reset = 1'b0; #2;
        chk("mrst_StallE", StallE, 0);
        chk("mrst_StallCnt", int'(StallCnt), 0);
        nxt(); reset = 1'b1; #2;
        chk("mrst_Done", MulDoneE, 0);
        chk("mrst_StallF", StallF, 0);
        nxt(); #2;
        chk("mrst_Done2", MulDoneE, 0);

        // Saturation then clear
        nxt(); MemtoRegE = 1; RegWriteE = 1; WA3E = 7; RA2D = 7;
        repeat (19) nxt();
        #2;
        chk("sat_StallCnt", int'(StallCnt), 15);
        nxt(); CntClr = 1;
        nxt(); CntClr = 0; quiet(); #2;
        chk("clr_StallCnt", int'(StallCnt), 0);
        chk("clr_FlushCnt", int'(FlushCnt), 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            nxt();
            reset        = ($urandom_range(0, 63) != 0);
            MulStartE    = ($urandom_range(0, 11) == 0);
            BranchTakenE = MulStartE ? 1'b0 : ($urandom_range(0, 5) == 0);
            MemtoRegE    = MulStartE ? 1'b0 : 1'($urandom_range(0, 1));
            RegWriteE    = 1'($urandom_range(0, 1));
            WA3E         = 4'($urandom_range(0, 3));
            RA1D         = 4'($urandom_range(0, 3));
            RA2D         = 4'($urandom_range(0, 3));
            CntClr       = ($urandom_range(0, 31) == 0);
        end
        nxt(); quiet();
        nxt(); nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. It drives the stall (enable) and flush (clear) inputs of the Fetch/Decode, Decode/Execute and Execute/Memory pipeline registers. It resolves load-use hazards and taken-branch flushes, and holds the pipeline for a multi-cycle multiply in Execute. Saturating counters of stall and flush cycles are exposed for performance measurement.

## Interface

- MUL_LAT, 4, cycles a multiply occupies Execute, including the issue cycle; legal range 1..15
- CNT_W, 16, width of the performance counters
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset
- RA1D, RA2D  input  4  source register addresses of the instruction in Decode
- WA3E  input  4  destination register of the instruction in Execute
- RegWriteE, MemtoRegE  input  1  the Execute instruction writes a register / is a load
- BranchTakenE  input  1  the Execute instruction redirects the PC this cycle
- MulStartE  input  1  the Execute instruction is a multiply; valid on its first Execute cycle only
- CntClr  input  1  synchronous clear of both counters
- StallF, StallD  output  1  hold the PC register and the Fetch/Decode register; the pipeline register enable is the inverse
- FlushD, FlushE  output  1  clear the Fetch/Decode and Decode/Execute registers
- StallE, FlushM  output  1  hold Decode/Execute; insert a bubble into Execute/Memory
- MulDoneE  output  1  last Execute cycle of a multiply
- StallCnt, FlushCnt  output  CNT_W  performance counters

## Operation

- FSM states: IDLE, MUL_BUSY. A 4-bit down-counter `mcnt` is used in MUL_BUSY.
- Load-use hazard: `lwstall = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D)`.
- Outputs in IDLE (combinational):
  - StallF = StallD = lwstall
  - FlushD = BranchTakenE
  - FlushE = lwstall | BranchTakenE
  - StallE = FlushM = 0
- Entering MUL_BUSY:
  - If IDLE, MulStartE=1 and MUL_LAT>1: go to MUL_BUSY and load mcnt = MUL_LAT-2.
  - In that issue cycle StallF = StallD = StallE = FlushM = 1 and MulDoneE = 0.
- MUL_LAT=1: a multiply never leaves IDLE, and MulDoneE = MulStartE.
- Outputs in MUL_BUSY:
  - StallF = StallD = StallE = FlushM = 1
  - FlushD = FlushE = 0
  - BranchTakenE, lwstall and MulStartE are ignored.
- Leaving MUL_BUSY: when mcnt==0, MulDoneE=1 and all stalls drop to 0 in that same cycle, so the multiply advances; next state is IDLE. Otherwise mcnt decrements.
- Simultaneous IDLE events:
  - BranchTakenE together with lwstall: both flushes assert, and StallF/StallD also assert. Flush takes priority at the Fetch/Decode register because its clear has priority over enable.
  - MulStartE together with BranchTakenE: this is illegal and is asserted against in simulation. The multiply wins.
- StallCnt increments on each cycle with StallF=1. FlushCnt increments on each cycle with FlushD|FlushE=1.
- Both counters saturate at all-ones. CntClr has priority over increment.

## Timing

- All hazard outputs are combinational from inputs and current state, with zero-cycle latency. Only the FSM, mcnt and the counters are registered.
- While reset=0, all outputs are forced to 0. On the next edge: state IDLE, mcnt=0, StallCnt=FlushCnt=0.
- A multiply issued at cycle t holds Execute for cycles t..t+MUL_LAT-1. MulDoneE is asserted at t+MUL_LAT-1, and Fetch resumes at t+MUL_LAT.
- Reset during MUL_BUSY aborts the multiply. There is no MulDoneE pulse, and the controller is in IDLE on the next cycle.
- A stall cycle caused by the issue or busy cycles of a multiply counts in StallCnt. The MulDoneE cycle does not.

## Structure

- Package `pipeline_ctrl_pkg` holds:
  - `typedef enum logic {IDLE, MUL_BUSY} pctrl_state_t`
  - the register-address width constant (4)
  - the default value for MUL_LAT
- Sub-module `sat_counter` (parameter W, with inc, clr and synchronous active-low reset) is instantiated twice, once per counter.
- The hazard equations stay inline in `pipeline_ctrl`.

## Test plan

- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA1D=5 for 1 cycle -> StallF=StallD=FlushE=1 and FlushD=0; StallCnt=1, FlushCnt=1.
- Branch: BranchTakenE=1 for 1 cycle, no hazard -> FlushD=FlushE=1, stalls 0; FlushCnt increments by 1.
- Multiply, MUL_LAT=4, MulStartE at cycle 10 -> StallE=FlushM=1 for cycles 10-12, MulDoneE=1 at cycle 13 with all stalls 0; StallCnt=3.
- Branch during MUL_BUSY (BranchTakenE=1 at cycle 11) -> FlushD=FlushE stay 0, and MulDoneE still occurs at cycle 13.
- Reset low at cycle 11 of a multiply -> all outputs 0 during reset; state IDLE afterwards, counters 0, no MulDoneE.
- Saturation, CNT_W=4: hold lwstall for 20 cycles -> StallCnt stops at 15. Then CntClr=1 together with lwstall -> StallCnt=0.
